tone_square_gen: RTL

Square-wave tone generator for the synthesizer voice path. It sits directly downstream of the clock-divider stage and consumes that stage's divided rate as a one-cycle `tick` enable on the system clock. It turns a latched note/octave selection into an audio-rate square wave for the output driver. Note changes are deferred to a full-period boundary so the output never carries a truncated (glitched) cycle.

---
 rtl/synth_pkg.sv | 32 +++
 rtl/note_period_rom.sv | 44 ++++
 rtl/tone_square_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synthesizer voice path. It holds the default
// widths, the note-code constants and the tone FSM state encoding.
// ---------------------------------------------------------------------------
package synth_pkg;

  localparam int CNT_W  = 16;
  localparam int NOTE_W = 4;
  localparam int OCT_W  = 2;

  // Note codes. 0 and 13..15 are rests.
  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_CS   = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_DS   = 4'd4;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_F    = 4'd6;
  localparam logic [3:0] NOTE_FS   = 4'd7;
  localparam logic [3:0] NOTE_G    = 4'd8;
  localparam logic [3:0] NOTE_GS   = 4'd9;
  localparam logic [3:0] NOTE_A    = 4'd10;
  localparam logic [3:0] NOTE_AS   = 4'd11;
  localparam logic [3:0] NOTE_B    = 4'd12;

  typedef enum logic {
    ST_REST = 1'b0,
    ST_PLAY = 1'b1
  } tone_state_t;

endpackage

// File: rtl/note_period_rom.sv
// ---------------------------------------------------------------------------
// note_period_rom
// Combinational lookup from a note code to its base half-period, measured
// in divider ticks (octave 0). Rest codes return 0 and raise o_is_rest.
// Ports:
//   i_note_code  note code to look up
//   o_base_hp    base half-period in ticks (0 for rest codes)
//   o_is_rest    high when the code is not playable
// ---------------------------------------------------------------------------
module note_period_rom #(
  parameter int NOTE_W = synth_pkg::NOTE_W,
  parameter int CNT_W  = synth_pkg::CNT_W
) (
  input  logic [NOTE_W-1:0] i_note_code,
  output logic [CNT_W-1:0]  o_base_hp,
  output logic              o_is_rest
);
  import synth_pkg::*;

  // Note-code to half-period table
  always_comb begin
    o_base_hp = '0;
    o_is_rest = 1'b0;
    case (i_note_code)
      NOTE_C:  o_base_hp = CNT_W'(16'd1911);
      NOTE_CS: o_base_hp = CNT_W'(16'd1804);
      NOTE_D:  o_base_hp = CNT_W'(16'd1703);
      NOTE_DS: o_base_hp = CNT_W'(16'd1607);
      NOTE_E:  o_base_hp = CNT_W'(16'd1517);
      NOTE_F:  o_base_hp = CNT_W'(16'd1432);
      NOTE_FS: o_base_hp = CNT_W'(16'd1351);
      NOTE_G:  o_base_hp = CNT_W'(16'd1276);
      NOTE_GS: o_base_hp = CNT_W'(16'd1204);
      NOTE_A:  o_base_hp = CNT_W'(16'd1136);
      NOTE_AS: o_base_hp = CNT_W'(16'd1073);
      NOTE_B:  o_base_hp = CNT_W'(16'd1012);
      default: begin
        o_base_hp = '0;
        o_is_rest = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tone_square_gen.sv
// ---------------------------------------------------------------------------
// tone_square_gen
// Square-wave tone generator. A half-period counter advances on each divider
// tick and toggles the output when it wraps. A new note requested while a
// tone plays is held pending and takes effect only at the falling edge of the
// output, which ends a full period. The output therefore never carries a
// truncated cycle.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tick         one-cycle rate enable from the clock divider
//   note_valid   strobe; samples note_code/octave
//   note_code    0 = rest, 1..12 = C..B, 13..15 = rest
//   octave       right shift applied to the base half-period
//   wave_out     registered square wave
//   note_active  high while a non-rest note is playing
//   period_done  one-cycle pulse on each completed full period
// ---------------------------------------------------------------------------
module tone_square_gen #(
  parameter int CNT_W  = synth_pkg::CNT_W,
  parameter int NOTE_W = synth_pkg::NOTE_W,
  parameter int OCT_W  = synth_pkg::OCT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_code,
  input  logic [OCT_W-1:0]  octave,
  output logic              wave_out,
  output logic              note_active,
  output logic              period_done
);
  import synth_pkg::*;

  tone_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_hp;
  logic              r_pend_vld;
  logic [NOTE_W-1:0] r_pend_code;
  logic [OCT_W-1:0]  r_pend_oct;
  logic              r_wave;
  logic              r_active;
  logic              r_done;

  logic [NOTE_W-1:0] w_sel_code;
  logic [OCT_W-1:0]  w_sel_oct;
  logic [CNT_W-1:0]  w_base_hp;
  logic              w_is_rest;
  logic [CNT_W-1:0]  w_sel_hp;
  logic              w_wrap;
  logic              w_boundary;
  logic              w_apply;

  // A single ROM serves both cases. A fresh strobe always takes priority,
  // which covers a start from REST and a strobe arriving on the boundary.
  // Otherwise the pending note is looked up for a boundary reload.
  assign w_sel_code = note_valid ? note_code : r_pend_code;
  assign w_sel_oct  = note_valid ? octave    : r_pend_oct;

  note_period_rom #(
    .NOTE_W (NOTE_W),
    .CNT_W  (CNT_W)
  ) u_rom (
    .i_note_code (w_sel_code),
    .o_base_hp   (w_base_hp),
    .o_is_rest   (w_is_rest)
  );

  assign w_sel_hp   = w_base_hp >> w_sel_oct;
  assign w_wrap     = tick && (r_cnt == (r_hp - CNT_W'(1'b1)));
  // Only the high-to-low toggle ends a full period.
  assign w_boundary = (r_state == ST_PLAY) && w_wrap && r_wave;
  assign w_apply    = note_valid || r_pend_vld;

  // Tone FSM: counter, pending-note register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_REST;
      r_cnt       <= '0;
      r_hp        <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_code <= '0;
      r_pend_oct  <= '0;
      r_wave      <= 1'b0;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_REST: begin
          r_wave   <= 1'b0;
          r_cnt    <= '0;
          r_active <= 1'b0;
          if (note_valid && !w_is_rest) begin
            r_hp     <= w_sel_hp;
            r_state  <= ST_PLAY;
            r_active <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_boundary) begin
            r_wave     <= 1'b0;
            r_done     <= 1'b1;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            if (w_apply) begin
              if (w_is_rest) begin
                r_state  <= ST_REST;
                r_active <= 1'b0;
              end else begin
                r_hp <= w_sel_hp;
              end
            end
          end else begin
            if (w_wrap) begin
              r_wave <= ~r_wave;
              r_cnt  <= '0;
            end else if (tick) begin
              r_cnt <= r_cnt + CNT_W'(1'b1);
            end
            // Last write wins; nothing audible changes until the boundary.
            if (note_valid) begin
              r_pend_vld  <= 1'b1;
              r_pend_code <= note_code;
              r_pend_oct  <= octave;
            end
          end
        end
        default: begin
          r_state  <= ST_REST;
          r_cnt    <= '0;
          r_wave   <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign wave_out    = r_wave;
  assign note_active = r_active;
  assign period_done = r_done;

endmodule
